// File: rtl/dram_ctrl.sv
// Fixed-latency data memory behind a req/ready/done handshake. While an access
// is in flight the controller stalls the core. The array itself is never reset.
module dram_ctrl #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int LAT    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              stall,
  output logic              busy
);

  typedef enum logic {IDLE, ACCESS} state_t;

  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic              ready_q;
  logic              busy_q;
  logic              done_q;
  logic [DATA_W-1:0] rdata_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic              accept;
  logic              complete;

  assign accept   = (state_q == IDLE) && req;
  assign complete = (state_q == ACCESS) && (cnt_q == 4'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req) begin
            state_q <= ACCESS;
            cnt_q   <= CNT_INIT;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        ACCESS: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            if (!we_q) rdata_q <= mem[addr_q];
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Holding registers only matter while ACCESS, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= we;
      addr_q  <= addr;
      wdata_q <= wdata;
    end
  end

  // An async reset forces state_q to IDLE, which drops complete and aborts the store.
  always_ff @(posedge clk) begin
    if (complete && we_q) mem[addr_q] <= wdata_q;
  end

  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign rdata = rdata_q;
  assign stall = req & ~ready_q;

endmodule

// File: tb/tb_dram_ctrl.sv
// Bench for dram_ctrl: a LAT=3 and a LAT=1 instance, directed scenarios plus
// randomized traffic checked against an array-based memory model.
module tb_dram_ctrl;

  logic             clk;
  logic             rst;
  logic [1:0]       req_v;
  logic [1:0]       we_v;
  logic [1:0][11:0] addr_v;
  logic [1:0][31:0] wdata_v;
  logic [1:0]       ready_v;
  logic [1:0]       done_v;
  logic [1:0][31:0] rdata_v;
  logic [1:0]       stall_v;
  logic [1:0]       busy_v;

  int n_chk;
  int n_fail;

  logic [31:0] mdl   [2][4096];
  bit          known [2][4096];
  logic [31:0] exp_rd[2];

  dram_ctrl #(.ADDR_W(12), .DATA_W(32), .LAT(3)) u_lat3 (
    .clk(clk), .rst(rst), .req(req_v[0]), .we(we_v[0]), .addr(addr_v[0]),
    .wdata(wdata_v[0]), .ready(ready_v[0]), .done(done_v[0]), .rdata(rdata_v[0]),
    .stall(stall_v[0]), .busy(busy_v[0])
  );

  dram_ctrl #(.ADDR_W(12), .DATA_W(32), .LAT(1)) u_lat1 (
    .clk(clk), .rst(rst), .req(req_v[1]), .we(we_v[1]), .addr(addr_v[1]),
    .wdata(wdata_v[1]), .ready(ready_v[1]), .done(done_v[1]), .rdata(rdata_v[1]),
    .stall(stall_v[1]), .busy(busy_v[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int lat_of(input int k);
    return (k == 0) ? 3 : 1;
  endfunction

  // Called at a negedge with the instance idle; returns at the negedge of the done cycle.
  task automatic access(input int k, input bit w, input logic [11:0] a,
                        input logic [31:0] d, input bit scramble);
    chk("ready_before_req", ready_v[k], 1);
    req_v[k] = 1'b1; we_v[k] = w; addr_v[k] = a; wdata_v[k] = d;
    for (int c = 0; c < lat_of(k); c++) begin
      @(negedge clk);
      chk("ready_in_access", ready_v[k], 0);
      chk("busy_in_access", busy_v[k], 1);
      chk("done_in_access", done_v[k], 0);
      chk("stall_in_access", stall_v[k], req_v[k]);
      chk("rdata_hold_in_access", rdata_v[k], exp_rd[k]);
      if (scramble) begin
        req_v[k] = 1'($urandom); we_v[k] = 1'($urandom);
        addr_v[k] = 12'($urandom); wdata_v[k] = $urandom;
      end
    end
    @(negedge clk);
    if (w) begin
      mdl[k][a] = d;
      known[k][a] = 1'b1;
    end else begin
      exp_rd[k] = mdl[k][a];
    end
    chk("done_pulse", done_v[k], 1);
    chk("ready_in_done", ready_v[k], 1);
    chk("busy_in_done", busy_v[k], 0);
    chk("rdata_at_done", rdata_v[k], exp_rd[k]);
    req_v[k] = 1'b0; we_v[k] = 1'b0;
  endtask

  task automatic idle_cycle(input int k);
    @(negedge clk);
    chk("idle_done_low", done_v[k], 0);
    chk("idle_ready", ready_v[k], 1);
    chk("idle_busy", busy_v[k], 0);
    chk("idle_stall", stall_v[k], 0);
    chk("idle_rdata", rdata_v[k], exp_rd[k]);
  endtask

  initial begin
    logic [11:0] ra;
    bit          rw;
    n_chk = 0;
    n_fail = 0;
    rst = 1'b0;
    req_v = '0; we_v = '0; addr_v = '0; wdata_v = '0;
    exp_rd[0] = '0; exp_rd[1] = '0;
    for (int i = 0; i < 4096; i++) begin
      known[0][i] = 1'b0; known[1][i] = 1'b0;
    end

    // Reset and idle
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_ready", ready_v[k], 1);
      chk("rst_done", done_v[k], 0);
      chk("rst_rdata", rdata_v[k], 0);
      chk("rst_busy", busy_v[k], 0);
      chk("rst_stall", stall_v[k], 0);
    end
    rst = 1'b1;
    idle_cycle(0);
    idle_cycle(1);

    // Store then load, LAT=3
    access(0, 1'b1, 12'h00A, 32'hDEADBEEF, 1'b0);
    access(0, 1'b0, 12'h00A, 32'h0, 1'b0);
    chk("load_deadbeef", rdata_v[0], 32'hDEADBEEF);
    idle_cycle(0);

    // Back-to-back read-after-write, LAT=1
    access(1, 1'b1, 12'hFFF, 32'h12345678, 1'b0);
    access(1, 1'b0, 12'hFFF, 32'h0, 1'b0);
    chk("raw_load", rdata_v[1], 32'h12345678);
    idle_cycle(1);

    // Inputs and req churn during an access must be ignored
    access(0, 1'b1, 12'h020, 32'hCAFEF00D, 1'b1);
    idle_cycle(0);
    access(0, 1'b0, 12'h020, 32'h0, 1'b0);
    chk("latched_store", rdata_v[0], 32'hCAFEF00D);
    access(1, 1'b1, 12'h021, 32'h0BADCAFE, 1'b1);
    idle_cycle(1);
    access(1, 1'b0, 12'h021, 32'h0, 1'b0);

    // Load result survives a following store
    access(0, 1'b1, 12'h001, 32'h1, 1'b0);
    access(0, 1'b0, 12'h001, 32'h0, 1'b0);
    access(0, 1'b1, 12'h002, 32'h2, 1'b0);
    chk("rdata_after_store", rdata_v[0], 32'h1);
    idle_cycle(0);

    // Reset one cycle into a store aborts it
    access(0, 1'b1, 12'h005, 32'h11111111, 1'b0);
    req_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 12'h005; wdata_v[0] = 32'hAAAA5555;
    @(negedge clk);
    chk("midstore_busy", busy_v[0], 1);
    rst = 1'b0;
    #1;
    chk("abort_ready", ready_v[0], 1);
    chk("abort_busy", busy_v[0], 0);
    chk("abort_done", done_v[0], 0);
    chk("abort_rdata", rdata_v[0], 0);
    exp_rd[0] = '0; exp_rd[1] = '0;
    we_v[0] = 1'b0;
    @(negedge clk);
    chk("req_in_reset_ignored", busy_v[0], 0);
    chk("req_in_reset_ready", ready_v[0], 1);
    rst = 1'b1;
    access(0, 1'b0, 12'h005, 32'h0, 1'b0);
    chk("abort_preserved", rdata_v[0], 32'h11111111);
    idle_cycle(0);

    // Randomized traffic on both latencies
    for (int k = 0; k < 2; k++) begin
      for (int n = 0; n < 40; n++) begin
        ra = 12'h100 + 12'($urandom_range(0, 7));
        rw = (known[k][ra] == 1'b0) ? 1'b1 : 1'($urandom);
        access(k, rw, ra, $urandom, 1'($urandom));
        if ($urandom_range(0, 1) == 0) idle_cycle(k);
      end
      idle_cycle(k);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dram_ctrl.md
Name: dram_ctrl

Overview:
- Data-memory stage downstream of the single-core processor. Consumes the core's 12-bit address, 32-bit store data and write-enable, and returns load data.
- Models a DRAM with a fixed multi-cycle access latency behind a req/ready/done handshake.
- Drives a stall signal that freezes the core's PC while an access is in flight.
- Holds the data array internally.

Parameters:
- ADDR_W, 12, address width; array depth = 2**ADDR_W words.
- DATA_W, 32, word width.
- LAT, 3, access latency in cycles; legal range 1..15.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-low reset.
- req  input  1  access request from the core.
- we  input  1  1 = store, 0 = load; sampled with req.
- addr  input  ADDR_W  word address (core AR_out).
- wdata  input  DATA_W  store data.
- ready  output  1  controller can accept a request this cycle.
- done  output  1  one-cycle pulse marking access completion.
- rdata  output  DATA_W  load data; valid when done=1 after a load.
- stall  output  1  core must hold PC/IR; equals req & ~ready.
- busy  output  1  an access is in flight.

Behaviour:
- Reset (rst=0, async): state=IDLE, ready=1, done=0, rdata=0, busy=0, latency counter=0. The memory array is NOT cleared.
- States:
  - IDLE: ready=1, busy=0.
  - ACCESS: ready=0, busy=1.
- Accept: at a rising edge with state=IDLE and req=1:
  - latch we, addr and wdata into holding registers;
  - counter<=LAT-1; state<=ACCESS.
  - Inputs may change freely after acceptance.
- ACCESS: at each edge, if counter!=0 then counter<=counter-1.
- Completion: at the edge where counter==0 in ACCESS (edge E0+LAT after accept edge E0):
  - store: mem[addr_h]<=wdata_h;
  - load: rdata<=mem[addr_h];
  - done<=1; state<=IDLE.
- done is high for exactly the one cycle after completion, then returns to 0. ready=1 in that same cycle.
- rdata holds its last load value until the next load completes. Stores do not alter rdata.
- Back-to-back: a req present in the done cycle is accepted at that edge, giving one access per LAT+1 cycles.
- req while busy: ignored (ready=0). It is not queued; the core holds req high via stall.
- Read-after-write to the same address, back-to-back: the load returns the newly stored value, because the store committed before the load was accepted.
- Address uses all ADDR_W bits: no out-of-range case, no wrap.
- LAT=1: ready low for exactly one cycle per access.
- Reset mid-ACCESS: the access is aborted with no memory write, done stays 0, and state returns to IDLE. A store whose completion edge coincides with rst assertion is not performed.
- A transaction is in flight only from an accepted edge onward. req=1 during reset is not accepted until the first edge after rst deasserts.

Test Plan:
- Reset then idle (LAT=3): rst low 2 cycles -> ready=1, done=0, rdata=0, busy=0, stall=0 while req=0.
- Store/load (LAT=3):
  - store addr=0x00A, wdata=0xDEADBEEF; accept edge E0 -> ready=0 for 3 cycles, done=1 in the cycle after E3;
  - then load 0x00A -> done after 3 more cycles, rdata=0xDEADBEEF;
  - stall=1 on every cycle that req=1 and ready=0.
- Back-to-back RAW (LAT=1):
  - store 0xFFF<-0x12345678, then load 0xFFF presented in the done cycle;
  - load accepted immediately, rdata=0x12345678 two cycles later;
  - accesses are 2 cycles apart.
- Ignored request: during an ACCESS, change addr/wdata/we and toggle req -> the in-flight access uses the latched values, and no extra done pulse occurs.
- Reset mid-store (LAT=3):
  - store 0x005<-0xAAAA5555 over prior contents 0x11111111; assert rst one cycle after accept;
  - after release, load 0x005 -> rdata=0x11111111 and ready=1.
- rdata hold: load 0x001 (=0x1) then store 0x002<-0x2 -> rdata stays 0x00000001 through and after the store's done pulse.
